imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 110 +++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for the boot-time image loader.
// The loader sits on the slave side; whatever feeds it the image holds the master side.
interface imem_loader_if #(
   parameter int IMEM_W = 13
);
   logic              start_i;
   logic [7:0]        rx_data_i;
   logic              rx_valid_i;
   logic              rx_ready_o;
   logic              wr_en_o;
   logic [IMEM_W-1:0] wr_addr_o;
   logic [31:0]       wr_data_o;
   logic              busy_o;
   logic              done_o;
   logic              err_o;

   modport master (
      output start_i, rx_data_i, rx_valid_i,
      input  rx_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, rx_data_i, rx_valid_i,
      output rx_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory image loader: takes a 16-bit little-endian word count, then that
// many little-endian 32-bit words, and writes them to consecutive word addresses.
module imem_loader #(
   parameter int IMEM_W = 13
) (
   input logic          clk_i,
   input logic          rst_ni,
   imem_loader_if.slave bus
);
   localparam int          IDX_W    = IMEM_W - 2;
   localparam int unsigned CAPACITY = 32'd1 << IDX_W;

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;

   state_t            state;
   state_t            state_next;
   logic [15:0]       count;
   logic [IDX_W-1:0]  word_idx;
   logic [1:0]        byte_cnt;
   logic [23:0]       word_buf;
   logic              rx_ready;
   logic              wr_en;
   logic              busy;
   logic              done;
   logic              err;
   logic [IMEM_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              xfer;
   logic              last_word;
   logic [15:0]       len_full;

   assign xfer      = bus.rx_valid_i & rx_ready;
   assign len_full  = {bus.rx_data_i, count[7:0]};
   assign last_word = (32'(word_idx) + 32'd1) == 32'(count);

   // The last word's write strobe coincides with entering DONE, so no byte is taken after it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERR: if (bus.start_i) state_next = LEN_LO;
         LEN_LO:          if (xfer) state_next = LEN_HI;
         LEN_HI: begin
            if (xfer) begin
               if (len_full == 16'd0)                state_next = DONE;
               else if (32'(len_full) > CAPACITY)    state_next = ERR;
               else                                  state_next = DATA;
            end
         end
         DATA:            if (xfer && byte_cnt == 2'd3 && last_word) state_next = DONE;
         default:         state_next = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         count    <= '0;
         word_idx <= '0;
         byte_cnt <= '0;
         word_buf <= '0;
         rx_ready <= 1'b0;
         wr_en    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         state    <= state_next;
         rx_ready <= (state_next == LEN_LO) || (state_next == LEN_HI) || (state_next == DATA);
         busy     <= (state_next == LEN_LO) || (state_next == LEN_HI) || (state_next == DATA);
         done     <= (state_next == DONE);
         err      <= (state_next == ERR);
         wr_en    <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (bus.start_i) begin
                  word_idx <= '0;
                  byte_cnt <= '0;
               end
            end
            LEN_LO: if (xfer) count[7:0]  <= bus.rx_data_i;
            LEN_HI: if (xfer) count[15:8] <= bus.rx_data_i;
            DATA: begin
               if (xfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     wr_en    <= 1'b1;
                     wr_data  <= {bus.rx_data_i, word_buf};
                     wr_addr  <= {word_idx, 2'b00};
                     word_idx <= word_idx + IDX_W'(1);
                  end else begin
                     word_buf[{byte_cnt, 3'b000} +: 8] <= bus.rx_data_i;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rx_ready_o = rx_ready;
   assign bus.wr_en_o    = wr_en;
   assign bus.wr_addr_o  = wr_addr;
   assign bus.wr_data_o  = wr_data;
   assign bus.busy_o     = busy;
   assign bus.done_o     = done;
   assign bus.err_o      = err;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a table of length/pacing cases plus hand-written corner sequences,
// with every instruction-memory write checked against a queue of expected writes.
module tb_imem_loader;
   localparam int IMEM_W = 13;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b1;

   always #5 clk_i = ~clk_i;

   imem_loader_if #(.IMEM_W(IMEM_W)) bus ();

   imem_loader #(.IMEM_W(IMEM_W)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   typedef struct {
      logic [IMEM_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   typedef struct {
      logic [15:0] len;
      bit          gapped;
      bit          holdStart;
      bit          expDone;
      bit          expErr;
   } loadVec_t;

   wr_t      sb[$];
   loadVec_t vecs[7];
   int       total = 0;
   int       bad   = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every write strobe must match the oldest outstanding expected write.
   always @(negedge clk_i) begin
      if (rst_ni && bus.wr_en_o === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                     bus.wr_addr_o, bus.wr_data_o);
         end else begin
            wr_t exp;
            exp = sb.pop_front();
            checkOutput("wr_addr", 32'(bus.wr_addr_o), 32'(exp.addr));
            checkOutput("wr_data", bus.wr_data_o, exp.data);
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b, input bit gap);
      if (gap) begin
         bus.rx_valid_i = 1'b0;
         @(posedge clk_i);
         #1;
      end
      bus.rx_data_i  = b;
      bus.rx_valid_i = 1'b1;
      for (int i = 0; i < 50 && bus.rx_ready_o !== 1'b1; i++) begin
         @(posedge clk_i);
         #1;
      end
      if (bus.rx_ready_o !== 1'b1) begin
         total++;
         bad++;
         $display("[TB] FAIL rx_ready_timeout: got rx_ready 0 expected 1 within 50 cycles");
      end else begin
         @(posedge clk_i);
         #1;
      end
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic pulseStart();
      bus.start_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
   endtask

   task automatic sendWord(input int idx, input logic [31:0] word, input bit gap);
      sb.push_back('{addr: IMEM_W'(idx << 2), data: word});
      for (int b = 0; b < 4; b++) applyStimulus(word[8*b +: 8], gap);
   endtask

   task automatic drainCheck();
      @(negedge clk_i);
      #1;
      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic runLoad(input logic [15:0] len, input bit gapped, input bit holdStart,
                          input bit expDone, input bit expErr);
      pulseStart();
      checkOutput("busy_after_start", 32'(bus.busy_o), 32'd1);
      checkOutput("flags_cleared", {30'd0, bus.done_o, bus.err_o}, 32'd0);
      if (holdStart) bus.start_i = 1'b1;
      applyStimulus(len[7:0], gapped);
      applyStimulus(len[15:8], gapped);
      if (!expErr) begin
         for (int w = 0; w < int'(len); w++) sendWord(w, $urandom(), gapped);
      end
      bus.start_i = 1'b0;
      checkOutput("done_end", 32'(bus.done_o), 32'(expDone));
      checkOutput("err_end", 32'(bus.err_o), 32'(expErr));
      checkOutput("busy_end", 32'(bus.busy_o), 32'd0);
      checkOutput("ready_end", 32'(bus.rx_ready_o), 32'd0);
      drainCheck();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] img[10];

      vecs[0] = '{16'd1,     1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{16'd3,     1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{16'd4,     1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{16'd0,     1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'd2049,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{16'hFFFF,  1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{16'd2,     1'b1, 1'b1, 1'b1, 1'b0};

      img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

      bus.start_i    = 1'b0;
      bus.rx_data_i  = 8'h00;
      bus.rx_valid_i = 1'b0;
      #1 rst_ni = 1'b0;
      #11;
      checkOutput("reset_outputs",
                  {27'd0, bus.rx_ready_o, bus.wr_en_o, bus.busy_o, bus.done_o, bus.err_o}, 32'd0);
      checkOutput("reset_addr", 32'(bus.wr_addr_o), 32'd0);
      checkOutput("reset_data", bus.wr_data_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Basic image at full rate, including ready staying high while a word is written.
      pulseStart();
      applyStimulus(img[0], 1'b0);
      applyStimulus(img[1], 1'b0);
      sb.push_back('{addr: IMEM_W'(0), data: 32'h0000_0013});
      sb.push_back('{addr: IMEM_W'(4), data: 32'h0010_0093});
      for (int i = 2; i < 6; i++) applyStimulus(img[i], 1'b0);
      checkOutput("wr_en_word0", 32'(bus.wr_en_o), 32'd1);
      checkOutput("ready_during_write", 32'(bus.rx_ready_o), 32'd1);
      for (int i = 6; i < 10; i++) applyStimulus(img[i], 1'b0);
      checkOutput("wr_en_last_word", 32'(bus.wr_en_o), 32'd1);
      checkOutput("basic_done", 32'(bus.done_o), 32'd1);
      checkOutput("basic_busy", 32'(bus.busy_o), 32'd0);
      checkOutput("basic_ready", 32'(bus.rx_ready_o), 32'd0);
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("hold_wr_en", 32'(bus.wr_en_o), 32'd0);
      checkOutput("hold_addr", 32'(bus.wr_addr_o), 32'h4);
      checkOutput("hold_data", bus.wr_data_o, 32'h0010_0093);
      checkOutput("done_sticky", 32'(bus.done_o), 32'd1);
      drainCheck();

      // Same image with an idle cycle before every byte.
      pulseStart();
      sb.push_back('{addr: IMEM_W'(0), data: 32'h0000_0013});
      sb.push_back('{addr: IMEM_W'(4), data: 32'h0010_0093});
      for (int i = 0; i < 10; i++) applyStimulus(img[i], 1'b1);
      checkOutput("gapped_done", 32'(bus.done_o), 32'd1);
      drainCheck();

      for (int v = 0; v < 7; v++)
         runLoad(vecs[v].len, vecs[v].gapped, vecs[v].holdStart, vecs[v].expDone, vecs[v].expErr);

      // Over capacity by one word: error is sticky until the next start.
      pulseStart();
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h08, 1'b0);
      checkOutput("ovf_err", 32'(bus.err_o), 32'd1);
      checkOutput("ovf_done", 32'(bus.done_o), 32'd0);
      checkOutput("ovf_ready", 32'(bus.rx_ready_o), 32'd0);
      bus.rx_valid_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      bus.rx_valid_i = 1'b0;
      checkOutput("ovf_err_sticky", 32'(bus.err_o), 32'd1);
      runLoad(16'd1, 1'b0, 1'b0, 1'b1, 1'b0);

      // Full capacity: last write lands at 0x1FFC.
      runLoad(16'd2048, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("full_last_addr", 32'(bus.wr_addr_o), 32'h1FFC);

      // Reset after six data bytes: one word written, second word abandoned.
      pulseStart();
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'h00, 1'b0);
      sendWord(0, 32'hCAFE_F00D, 1'b0);
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      rst_ni = 1'b0;
      #1;
      checkOutput("midreset_outputs",
                  {27'd0, bus.rx_ready_o, bus.wr_en_o, bus.busy_o, bus.done_o, bus.err_o}, 32'd0);
      checkOutput("midreset_addr", 32'(bus.wr_addr_o), 32'd0);
      checkOutput("midreset_data", bus.wr_data_o, 32'd0);
      checkOutput("midreset_sb", 32'(sb.size()), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      bus.rx_data_i  = 8'hAA;
      bus.rx_valid_i = 1'b1;
      repeat (5) @(posedge clk_i);
      #1;
      bus.rx_valid_i = 1'b0;
      checkOutput("postreset_idle", {30'd0, bus.busy_o, bus.rx_ready_o}, 32'd0);
      runLoad(16'd1, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
